// File: rtl/riscv_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch_buf
// Purpose  : Instruction-fetch front end. Owns the fetch PC, issues requests
//            to a variable-latency instruction memory and buffers up to DEPTH
//            in-order, PC-tagged responses for decode. A redirect flushes the
//            buffer and discards responses that are still in flight.
// Revision : 1.0  initial release
// ============================================================================
module riscv_fetch_buf #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  // instruction memory request
  output logic                       imem_req_valid_o,
  input  logic                       imem_req_ready_i,
  output logic [XLEN-1:0]            imem_req_addr_o,
  // instruction memory response
  input  logic                       imem_rsp_valid_i,
  input  logic [31:0]                imem_rsp_data_i,
  // redirect from execute
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  // decode side
  output logic                       inst_valid_o,
  output logic [31:0]                inst_o,
  output logic [XLEN-1:0]            inst_pc_o,
  input  logic                       inst_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]  C_DEPTH = (CW + 1)'(DEPTH);
  localparam logic [31:0]  C_NOP   = 32'h0000_0013;

  // Control state
  logic [XLEN-1:0]  fetch_pc_q;
  logic [PW-1:0]    alloc_ptr_q, fill_ptr_q, rd_ptr_q;
  logic [CW-1:0]    occ_q, occ_d;      // pending + filled slots
  logic [CW-1:0]    pend_q, pend_d;    // allocated, response not yet received
  logic [CW-1:0]    drop_q, drop_d;    // stale responses still to be discarded
  logic [DEPTH-1:0] filled_q;

  // Slot payload (no reset needed: only read when the slot is filled)
  logic [XLEN-1:0]  slot_pc_q   [DEPTH];
  logic [31:0]      slot_inst_q [DEPTH];

  logic             req_fire;
  logic             rsp_keep;
  logic             rsp_drop;
  logic             pop;
  logic [CW:0]      occ_plus_drop;
  logic [CW-1:0]    drop_sum;
  logic [1:0]       unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc_i[1:0];

  // Stale responses still count against capacity so a flushed memory
  // pipeline can never hold more than DEPTH outstanding transactions.
  assign occ_plus_drop    = {1'b0, occ_q} + {1'b0, drop_q};
  assign imem_req_valid_o = !rst && !redirect_i && (occ_plus_drop < C_DEPTH);
  assign imem_req_addr_o  = fetch_pc_q;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  // A response is discarded while stale ones are owed; a response with no
  // pending slot is a protocol error and is ignored rather than written.
  assign rsp_drop = imem_rsp_valid_i && (drop_q != '0);
  assign rsp_keep = imem_rsp_valid_i && (drop_q == '0) && (pend_q != '0) && !redirect_i;

  assign inst_valid_o = filled_q[rd_ptr_q];
  assign inst_o       = inst_valid_o ? slot_inst_q[rd_ptr_q] : C_NOP;
  assign inst_pc_o    = inst_valid_o ? slot_pc_q[rd_ptr_q]   : '0;
  assign pop          = inst_valid_o && inst_ready_i;
  assign occupancy_o  = occ_q;

  // Everything still pending at a redirect becomes stale, except a response
  // arriving in the redirect cycle itself, which is consumed right there.
  assign drop_sum = drop_q + pend_q;

  // Next-state for the slot and stale-response counters
  always_comb begin
    occ_d  = occ_q;
    pend_d = pend_q;
    drop_d = drop_q;
    if (redirect_i) begin
      occ_d  = '0;
      pend_d = '0;
      drop_d = (imem_rsp_valid_i && (drop_sum != '0)) ? drop_sum - CW'(1) : drop_sum;
    end else begin
      occ_d  = occ_q + CW'(req_fire) - CW'(pop);
      pend_d = pend_q + CW'(req_fire) - CW'(rsp_keep);
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  // Fetch PC, ring pointers, filled flags and counters; redirect overrides all
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      pend_q      <= '0;
      drop_q      <= '0;
      filled_q    <= '0;
    end else if (redirect_i) begin
      fetch_pc_q  <= {redirect_pc_i[XLEN-1:2], 2'b00};
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      filled_q    <= '0;
    end else begin
      if (req_fire) begin
        alloc_ptr_q <= alloc_ptr_q + PW'(1);
        fetch_pc_q  <= fetch_pc_q + XLEN'(4);
      end
      // pop and fill never target the same slot: the read slot is filled,
      // the fill slot is not
      if (pop) begin
        filled_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q           <= rd_ptr_q + PW'(1);
      end
      if (rsp_keep) begin
        filled_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q           <= fill_ptr_q + PW'(1);
      end
      occ_q  <= occ_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  // Slot payload writes: PC on allocation, instruction on a kept response
  always_ff @(posedge clk) begin
    if (req_fire) begin
      slot_pc_q[alloc_ptr_q] <= fetch_pc_q;
    end
    if (rsp_keep && !rst) begin
      slot_inst_q[fill_ptr_q] <= imem_rsp_data_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_fetch_buf
// Purpose  : Self-checking bench for riscv_fetch_buf with a behavioural
//            variable-latency memory and a PC/instruction scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_riscv_fetch_buf;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o, inst_pc_o;
  logic [2:0]  occupancy_o;

  riscv_fetch_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_ready_i     (inst_ready_i),
    .occupancy_o      (occupancy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] pc; bit filled; } slot_t;

  mreq_t       memq[$];    // memory model: accepted requests in order
  slot_t       expq[$];    // scoreboard: expected buffer contents
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_fetch;
  bit          g_acc, g_vld, g_rsp, g_pop;
  logic [31:0] g_acc_addr, g_pop_pc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // One clock cycle: drive inputs, check outputs against the model, update
  // memory and scoreboard at the edge. Entered and left at a falling edge.
  task automatic cycle(input bit mrdy, input bit drdy, input bit redir, input logic [31:0] rpc);
    int  stale_n;
    bit  exp_vld, exp_req, rsp_stale;
    imem_req_ready_i = mrdy;
    inst_ready_i     = drdy;
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    g_rsp            = (memq.size() > 0) && (memq[0].due <= cyc + 1);
    imem_rsp_valid_i = g_rsp;
    imem_rsp_data_i  = g_rsp ? memfn(memq[0].addr) : 32'hDEAD_BEEF;
    #1;
    stale_n = 0;
    foreach (memq[i]) if (memq[i].stale) stale_n++;
    exp_req = !redir && (expq.size() + stale_n < DEPTH);
    checks++;
    if (imem_req_valid_o !== exp_req) begin
      failures++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid_o, exp_req);
    end
    if (imem_req_valid_o === 1'b1) begin
      checks++;
      if (imem_req_addr_o !== exp_fetch) begin
        failures++;
        $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr_o, exp_fetch);
      end
    end
    checks++;
    if (occupancy_o !== 3'(expq.size())) begin
      failures++;
      $display("FAIL occupancy cyc=%0d got=%0d exp=%0d", cyc, occupancy_o, expq.size());
    end
    exp_vld = (expq.size() > 0) && expq[0].filled;
    checks++;
    if (inst_valid_o !== exp_vld) begin
      failures++;
      $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid_o, exp_vld);
    end
    checks++;
    if (exp_vld) begin
      if (inst_pc_o !== expq[0].pc || inst_o !== memfn(expq[0].pc)) begin
        failures++;
        $display("FAIL inst_data cyc=%0d got pc=%h inst=%h exp pc=%h inst=%h",
                 cyc, inst_pc_o, inst_o, expq[0].pc, memfn(expq[0].pc));
      end
    end else if (inst_o !== NOP || inst_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL inst_idle cyc=%0d got pc=%h inst=%h exp pc=0 inst=%h", cyc, inst_pc_o, inst_o, NOP);
    end
    g_vld      = inst_valid_o;
    g_pop      = exp_vld && drdy && !redir;
    g_pop_pc   = inst_pc_o;
    g_acc      = imem_req_valid_o && mrdy;
    g_acc_addr = imem_req_addr_o;
    @(posedge clk);
    cyc++;
    if (g_pop) void'(expq.pop_front());
    rsp_stale = 1'b0;
    if (g_rsp) begin
      rsp_stale = memq[0].stale;
      void'(memq.pop_front());
    end
    if (redir) begin
      expq.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      exp_fetch = {rpc[31:2], 2'b00};
    end else begin
      if (g_rsp && !rsp_stale) begin
        bit placed = 1'b0;
        for (int i = 0; i < expq.size(); i++) begin
          if (!placed && !expq[i].filled) begin
            expq[i].filled = 1'b1;
            placed = 1'b1;
          end
        end
        if (!placed) begin
          failures++;
          $display("FAIL rsp_orphan cyc=%0d got=response exp=no_response", cyc);
        end
      end
      if (exp_req && mrdy) begin
        expq.push_back('{exp_fetch, 1'b0});
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    if (g_acc) memq.push_back('{g_acc_addr, cyc + lat, 1'b0});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    imem_req_ready_i = 1'b0;
    inst_ready_i     = 1'b0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    @(posedge clk);
    cyc++;
    memq.delete();
    expq.delete();
    exp_fetch = RPC;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (imem_req_valid_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== NOP ||
        inst_pc_o !== 32'h0 || occupancy_o !== 3'd0) begin
      failures++;
      $display("FAIL %s got reqv=%b v=%b inst=%h pc=%h occ=%0d exp reqv=0 v=0 inst=%h pc=0 occ=0",
               tag, imem_req_valid_o, inst_valid_o, inst_o, inst_pc_o, occupancy_o, NOP);
    end
  endtask

  task automatic release_reset(input string tag);
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== RPC) begin
      failures++;
      $display("FAIL %s got reqv=%b addr=%h exp reqv=1 addr=%h", tag, imem_req_valid_o, imem_req_addr_o, RPC);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_outputs("reset_values");
    release_reset("reset_release");
  endtask

  task automatic test_stream();
    int first_acc = -1, first_vld = -1, npop = 0;
    logic [31:0] first_pc = '0;
    lat = 1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (g_acc && first_acc < 0) first_acc = i;
      if (g_vld && first_vld < 0) begin
        first_vld = i;
        first_pc  = g_pop_pc;
      end
      if (i >= 8 && g_pop) npop++;
    end
    checks++;
    if (first_vld - first_acc != 2) begin
      failures++;
      $display("FAIL stream_latency got=%0d exp=2", first_vld - first_acc);
    end
    checks++;
    if (first_pc !== RPC) begin
      failures++;
      $display("FAIL stream_first_pc got=%h exp=%h", first_pc, RPC);
    end
    checks++;
    if (npop != 8) begin
      failures++;
      $display("FAIL stream_throughput got=%0d exp=8", npop);
    end
  endtask

  task automatic test_stall();
    int nacc = 0;
    bit have = 1'b0;
    logic [31:0] hold_pc = '0, hold_inst = '0;
    logic [31:0] pops[$];
    do_reset();
    release_reset("stall_release");
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      if (g_acc) nacc++;
      if (g_vld) begin
        if (!have) begin
          have = 1'b1;
          hold_pc = inst_pc_o;
          hold_inst = inst_o;
        end
        checks++;
        if (inst_pc_o !== hold_pc || inst_o !== hold_inst) begin
          failures++;
          $display("FAIL stall_stable got pc=%h inst=%h exp pc=%h inst=%h", inst_pc_o, inst_o, hold_pc, hold_inst);
        end
      end
    end
    checks++;
    if (nacc != DEPTH) begin
      failures++;
      $display("FAIL stall_accepts got=%0d exp=%0d", nacc, DEPTH);
    end
    checks++;
    if (imem_req_valid_o !== 1'b0 || occupancy_o !== 3'(DEPTH)) begin
      failures++;
      $display("FAIL stall_full got reqv=%b occ=%0d exp reqv=0 occ=%0d", imem_req_valid_o, occupancy_o, DEPTH);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (g_pop) pops.push_back(g_pop_pc);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pops.size() <= k || pops[k] !== RPC + 32'(4 * k)) begin
        failures++;
        $display("FAIL stall_drain_%0d got=%h exp=%h", k, (pops.size() > k) ? pops[k] : 32'hX, RPC + 32'(4 * k));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    int n = 0;
    bit got = 1'b0;
    do_reset();
    release_reset("redir_release");
    lat = 3;
    while (memq.size() < 3 && n < 20) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      n++;
    end
    checks++;
    if (memq.size() != 3) begin
      failures++;
      $display("FAIL redir_setup_timeout got=%0d exp=3", memq.size());
    end
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_2003);
    checks++;
    if (imem_req_addr_o !== 32'h0000_2000) begin
      failures++;
      $display("FAIL redir_addr got=%h exp=00002000", imem_req_addr_o);
    end
    for (int i = 0; i < 30 && !got; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (g_pop) begin
        got = 1'b1;
        checks++;
        if (g_pop_pc !== 32'h0000_2000) begin
          failures++;
          $display("FAIL redir_first_pc got=%h exp=00002000", g_pop_pc);
        end
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL redir_output_timeout got=none exp=pc_00002000");
    end
  endtask

  task automatic test_redirect_pop();
    bit got = 1'b0;
    do_reset();
    release_reset("rpop_release");
    lat = 1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_3000);
    checks++;
    if (!(g_rsp && g_vld)) begin
      failures++;
      $display("FAIL rpop_precondition got rsp=%b vld=%b exp rsp=1 vld=1", g_rsp, g_vld);
    end
    checks++;
    if (inst_valid_o !== 1'b0 || inst_o !== NOP || occupancy_o !== 3'd0) begin
      failures++;
      $display("FAIL rpop_empty got v=%b inst=%h occ=%0d exp v=0 inst=%h occ=0", inst_valid_o, inst_o, occupancy_o, NOP);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (g_pop && !got) begin
        got = 1'b1;
        checks++;
        if (g_pop_pc !== 32'h0000_3000) begin
          failures++;
          $display("FAIL rpop_first_pc got=%h exp=00003000", g_pop_pc);
        end
      end
    end
  endtask

  task automatic test_ready_toggle_wrap();
    logic [31:0] accs[$];
    logic [31:0] want[4];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    want[3] = 32'h0000_0004;
    lat = 1;
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 14; i++) begin
      cycle((i % 2 == 0) || (i > 7), 1'b1, 1'b0, '0);
      if (g_acc) accs.push_back(g_acc_addr);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (accs.size() <= k || accs[k] !== want[k]) begin
        failures++;
        $display("FAIL wrap_seq_%0d got=%h exp=%h", k, (accs.size() > k) ? accs[k] : 32'hX, want[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, nf;
    bit got = 1'b0;
    do_reset();
    release_reset("mid_release");
    lat = 4;
    nf = 0;
    while (!(expq.size() == 4 && nf == 2) && n < 30) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      nf = 0;
      foreach (expq[i]) if (expq[i].filled) nf++;
      n++;
    end
    checks++;
    if (expq.size() != 4 || nf != 2) begin
      failures++;
      $display("FAIL mid_setup_timeout got alloc=%0d filled=%0d exp alloc=4 filled=2", expq.size(), nf);
    end
    do_reset();
    check_reset_outputs("mid_reset_values");
    release_reset("mid_restart");
    lat = 1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, '0);
      if (g_pop && !got) begin
        got = 1'b1;
        checks++;
        if (g_pop_pc !== RPC) begin
          failures++;
          $display("FAIL mid_first_pc got=%h exp=%h", g_pop_pc, RPC);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int npop = 0;
    do_reset();
    release_reset("b2b_release");
    lat = 2;
    for (int i = 0; i < 80; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0, '0);
      if (g_pop) npop++;
    end
    checks++;
    if (npop < 20) begin
      failures++;
      $display("FAIL b2b_progress got=%0d exp>=20", npop);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_pop();
    test_ready_toggle_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
